// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: byte width, frame timing defaults,
// scheduler state encoding and a small index-width helper.
package uart_pkg;

    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned FRAME_TICKS_DEFAULT = 10;
    localparam int unsigned GAP_TICKS_DEFAULT   = 1;
    localparam int unsigned GRANT_ID_W          = 3;
    localparam int unsigned FRAME_CNT_W         = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2
    } sched_state_e;

    // A single requester still needs a one-bit index so ports never collapse to zero width.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Producer-side valid/ready/data bundle shared by all byte sources feeding the scheduler.
// master = producers, slave = scheduler.
interface uart_tx_scheduler_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < int'(N); k++) begin
            cand = IDX_W'((int'(ptr) + k) % int'(N));
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte producers; frame occupancy is timed
// by counting the shared baud_tick since uart_tx exposes no busy flag.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEFAULT,
    parameter int unsigned GAP_TICKS   = GAP_TICKS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   baud_tick,
    uart_tx_scheduler_if.slave     req_bus,
    output logic                   tx_start,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   busy,
    output logic [GRANT_ID_W-1:0]  grant_id,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned IdxW      = idx_width(NUM_REQ);
    localparam int unsigned SlotTicks = FRAME_TICKS + GAP_TICKS;
    localparam int unsigned CntW      = $clog2(SlotTicks + 1);

    localparam logic [CntW-1:0] LastTick = CntW'(SlotTicks - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);

    sched_state_e           state_q;
    logic [IdxW-1:0]        ptr_q;
    logic [CntW-1:0]        tick_cnt_q;
    logic                   start_q;
    logic                   busy_q;
    logic [BYTE_W-1:0]      data_q;
    logic [GRANT_ID_W-1:0]  grant_id_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IdxW-1:0]    arb_index;
    logic               arb_any;
    logic               accept;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IdxW)
    ) u_rr_arbiter (
        .req   (req_bus.req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .index (arb_index),
        .any   (arb_any)
    );

    // Ready is derived from valid only, so producers may wait on ready without a loop.
    always_comb begin
        accept            = (state_q == StIdle) && enable && arb_any;
        req_bus.req_ready = accept ? arb_grant : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            tick_cnt_q  <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            grant_id_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        data_q     <= req_bus.req_data[BYTE_W*arb_index +: BYTE_W];
                        grant_id_q <= GRANT_ID_W'(arb_index);
                        ptr_q      <= (arb_index == LastIdx) ? '0 : arb_index + 1'b1;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StLaunch;
                    end
                end
                StLaunch: begin
                    // A baud_tick landing here belongs to no counted slot.
                    start_q     <= 1'b0;
                    tick_cnt_q  <= '0;
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == LastTick) begin
                            tick_cnt_q <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus a randomized run compared
// cycle by cycle against a transaction-level model of the arbitration and frame timing.
module tb_uart_tx_scheduler;

    localparam int N    = 4;
    localparam int SLOT = 11;  // FRAME_TICKS + GAP_TICKS counted per frame

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        enable    = 1'b0;
    logic        baud_tick = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [2:0]  grant_id;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    bit tick_log[$];
    int start_cyc[$];

    uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ     (N),
        .FRAME_TICKS (10),
        .GAP_TICKS   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .baud_tick (baud_tick),
        .req_bus   (bus),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin : baud_gen
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Reference model: a scheduler is either free, launching, or owes a number of ticks.
    int          m_ptr   = 0;
    logic        m_start = 1'b0;
    logic        m_busy  = 1'b0;
    int          m_left  = 0;
    logic [7:0]  m_data  = '0;
    logic [2:0]  m_gid   = '0;
    logic [15:0] m_cnt   = '0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (m_busy || !enable) return r;
        g = pick(bus.req_valid, m_ptr);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   <= 0;
            m_start <= 1'b0;
            m_busy  <= 1'b0;
            m_left  <= 0;
            m_data  <= '0;
            m_gid   <= '0;
            m_cnt   <= '0;
        end else if (m_start) begin
            m_start <= 1'b0;
            m_cnt   <= m_cnt + 16'd1;
            m_left  <= SLOT;
        end else if (m_busy) begin
            if (baud_tick) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_busy <= 1'b0;
            end
        end else if (enable && (bus.req_valid != '0)) begin
            m_gid   <= 3'(pick(bus.req_valid, m_ptr));
            m_data  <= bus.req_data[8*pick(bus.req_valid, m_ptr) +: 8];
            m_ptr   <= (pick(bus.req_valid, m_ptr) + 1) % N;
            m_start <= 1'b1;
            m_busy  <= 1'b1;
        end
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        repeat (2) @(negedge clk);
        #1;
        tests += 6;
        if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_start got %b exp 0", tx_start); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", tx_data); end
        if (grant_id !== 3'd0) begin fails++; $display("FAIL reset_gid got %0d exp 0", grant_id); end
        if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_fcnt got %0d exp 0", frame_cnt); end
        if (bus.req_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int ticks = 0;
        bit done = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid = 4'b0001;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0001) begin
            fails++; $display("FAIL single_ready got %b exp 0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        tests++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1 || grant_id !== 3'd0) begin
            fails++;
            $display("FAIL single_launch got start=%b data=%h busy=%b gid=%0d exp 1 A5 1 0",
                     tx_start, tx_data, busy, grant_id);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (baud_tick) ticks++;
        end
        tests += 3;
        if (!done || ticks != SLOT) begin
            fails++; $display("FAIL single_busy_ticks got %0d exp %0d", ticks, SLOT);
        end
        if (frame_cnt !== 16'd1) begin fails++; $display("FAIL single_fcnt got %0d exp 1", frame_cnt); end
        if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_hold got %h exp A5", tx_data); end
    endtask

    task automatic test_rotation();
        int n = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_data = 32'h44332211;
        bus.req_valid = 4'hF;
        enable = 1'b1;
        tick_log.delete();
        start_cyc.delete();
        cyc = 0;
        for (int i = 0; i < 400 && n < 3; i++) begin
            @(negedge clk); #1;
            tick_log.push_back(baud_tick);
            if (tx_start) begin
                tests++;
                if (grant_id !== 3'(n) || tx_data !== 8'(8'h11 * (n + 1))) begin
                    fails++;
                    $display("FAIL rot_grant%0d got gid=%0d data=%h exp gid=%0d data=%h",
                             n, grant_id, tx_data, n, 8'(8'h11 * (n + 1)));
                end
                start_cyc.push_back(cyc);
                n++;
                if (n == 3) bus.req_valid = 4'b1001;
            end
            cyc++;
        end
        tests++;
        if (n != 3) begin fails++; $display("FAIL rot_timeout got %0d grants exp 3", n); end
        for (int k = 1; k < start_cyc.size(); k++) begin
            int t = 0;
            for (int c = start_cyc[k-1] + 1; c <= start_cyc[k] - 2; c++) t += int'(tick_log[c]);
            tests++;
            if (t != SLOT || !tick_log[start_cyc[k] - 2]) begin
                fails++; $display("FAIL rot_spacing%0d got %0d ticks exp %0d", k, t, SLOT);
            end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        int base = start_cyc.size();
        for (int i = 0; i < 400 && n < 2; i++) begin
            @(negedge clk); #1;
            tick_log.push_back(baud_tick);
            if (tx_start) begin
                tests++;
                if (grant_id !== ((n == 0) ? 3'd3 : 3'd0) ||
                    tx_data !== ((n == 0) ? 8'h44 : 8'h11)) begin
                    fails++;
                    $display("FAIL wrap_grant%0d got gid=%0d data=%h exp gid=%0d",
                             n, grant_id, tx_data, (n == 0) ? 3 : 0);
                end
                start_cyc.push_back(cyc);
                n++;
                if (n == 2) bus.req_valid = 4'b0010;
            end
            cyc++;
        end
        tests++;
        if (n != 2) begin fails++; $display("FAIL wrap_timeout got %0d grants exp 2", n); end
        for (int k = (base > 0 ? base : 1); k < start_cyc.size(); k++) begin
            int t = 0;
            for (int c = start_cyc[k-1] + 1; c <= start_cyc[k] - 2; c++) t += int'(tick_log[c]);
            tests++;
            if (t != SLOT || !tick_log[start_cyc[k] - 2]) begin
                fails++; $display("FAIL wrap_spacing%0d got %0d ticks exp %0d", k, t, SLOT);
            end
        end
    endtask

    task automatic test_enable();
        bit ok;
        bit bad = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL en_idle_timeout got busy=%b exp 0", busy); end
        for (int i = 0; i < 30; i++) begin
            if (bus.req_ready !== 4'b0000 || tx_start !== 1'b0) bad = 1'b1;
            @(negedge clk); #1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL en_disabled_grant got activity exp none"); end
        enable = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0010) begin
            fails++; $display("FAIL en_resume_ready got %b exp 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        tests++;
        if (tx_start !== 1'b1 || grant_id !== 3'd1 || tx_data !== 8'h22) begin
            fails++;
            $display("FAIL en_resume_launch got start=%b gid=%0d data=%h exp 1 1 22",
                     tx_start, grant_id, tx_data);
        end
    endtask

    task automatic test_reset_mid();
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests += 3;
        if (tx_start !== 1'b0) begin fails++; $display("FAIL rmid_start got %b exp 0", tx_start); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", busy); end
        if (frame_cnt !== 16'd0 || grant_id !== 3'd0 || tx_data !== 8'h00) begin
            fails++;
            $display("FAIL rmid_regs got fcnt=%0d gid=%0d data=%h exp 0 0 00",
                     frame_cnt, grant_id, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0001) begin
            fails++; $display("FAIL rmid_tie_ready got %b exp 0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    task automatic test_frame_wrap();
        bit ok;
        int starts = 0;
        bit checked = 1'b0;
        enable = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL fw_idle_timeout got busy=%b exp 0", busy); end
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        bus.req_valid = 4'b0001;
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (tx_start) begin
                starts++;
                bus.req_valid = '0;
            end else if (starts > 0 && !checked) begin
                checked = 1'b1;
                tests++;
                if (frame_cnt !== 16'h0000) begin
                    fails++; $display("FAIL fw_wrap got %h exp 0000", frame_cnt);
                end
            end
            if (starts > 0 && !busy) break;
        end
        tests++;
        if (starts != 1 || !checked) begin
            fails++; $display("FAIL fw_start_pulses got %0d exp 1", starts);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.req_valid = N'($urandom);
            if ($urandom_range(0, 3) == 0) bus.req_data = $urandom;
            enable = ($urandom_range(0, 9) != 0);
            #1;
            er = model_ready();
            tests += 6;
            if (bus.req_ready !== er) begin
                fails++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, bus.req_ready, er);
            end
            if (tx_start !== m_start) begin
                fails++; $display("FAIL rnd_start cyc %0d got %b exp %b", i, tx_start, m_start);
            end
            if (busy !== m_busy) begin
                fails++; $display("FAIL rnd_busy cyc %0d got %b exp %b", i, busy, m_busy);
            end
            if (tx_data !== m_data) begin
                fails++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, tx_data, m_data);
            end
            if (grant_id !== m_gid) begin
                fails++; $display("FAIL rnd_gid cyc %0d got %0d exp %0d", i, grant_id, m_gid);
            end
            if (frame_cnt !== m_cnt) begin
                fails++; $display("FAIL rnd_fcnt cyc %0d got %0d exp %0d", i, frame_cnt, m_cnt);
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.req_valid = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_frame_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
